// File: rtl/axi4_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_master
// Description : Single-outstanding AXI4 burst master that bridges a command
//               port and write/read beat streams onto the AXI channels.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,

    output logic                  done,
    output logic [1:0]            done_resp,

    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,

    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,

    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,

    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,

    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    input  logic                  RLAST,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } state_t;

    localparam int                c_WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE   = c_WD_W'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [7:0]            r_beat_cnt;
    logic [1:0]            r_acc_resp;
    logic [c_WD_W-1:0]     r_wdog;

    logic                  w_hs;
    logic                  w_timeout;
    logic                  w_beat_last;
    logic [1:0]            w_r_resp;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_beat_last = (r_beat_cnt == r_len);
    assign w_timeout   = (r_state != ST_IDLE) && (r_wdog == c_WD_LIMIT);
    assign w_r_resp    = resp_max(r_acc_resp, RRESP);

    // Address channel fields come straight from the captured command.
    assign AWADDR = r_addr;
    assign AWLEN  = r_len;
    assign AWSIZE = r_size;
    assign ARADDR = r_addr;
    assign ARLEN  = r_len;
    assign ARSIZE = r_size;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_hs         = 1'b0;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        rd_last      = 1'b0;
        done         = 1'b0;
        done_resp    = 2'b00;
        AWVALID      = 1'b0;
        WDATA        = '0;
        WVALID       = 1'b0;
        WLAST        = 1'b0;
        BREADY       = 1'b0;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) begin
                    w_hs         = 1'b1;
                    w_next_state = ST_W;
                end
            end
            ST_W: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                WDATA    = wr_data;
                WLAST    = w_beat_last;
                if (wr_valid && WREADY) begin
                    w_hs = 1'b1;
                    if (w_beat_last) begin
                        w_next_state = ST_B;
                    end
                end
            end
            ST_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    w_hs         = 1'b1;
                    done         = 1'b1;
                    done_resp    = BRESP;
                    w_next_state = ST_IDLE;
                end
            end
            ST_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    w_hs         = 1'b1;
                    w_next_state = ST_R;
                end
            end
            ST_R: begin
                rd_valid = RVALID;
                RREADY   = rd_ready;
                rd_data  = RDATA;
                rd_last  = RLAST || w_beat_last;
                if (RVALID && rd_ready) begin
                    w_hs = 1'b1;
                    if (RLAST || w_beat_last) begin
                        done         = 1'b1;
                        // An RLAST arriving before the expected count is a protocol error.
                        done_resp    = (RLAST && !w_beat_last) ? resp_max(w_r_resp, 2'b10) : w_r_resp;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Watchdog expiry silences every channel so the slave sees no handshake.
        if (w_timeout) begin
            w_hs         = 1'b0;
            wr_ready     = 1'b0;
            rd_valid     = 1'b0;
            rd_data      = '0;
            rd_last      = 1'b0;
            AWVALID      = 1'b0;
            WDATA        = '0;
            WVALID       = 1'b0;
            WLAST        = 1'b0;
            BREADY       = 1'b0;
            ARVALID      = 1'b0;
            RREADY       = 1'b0;
            done         = 1'b1;
            done_resp    = 2'b11;
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_beat_cnt <= '0;
            r_acc_resp <= '0;
            r_wdog     <= '0;
        end else begin
            if ((r_state == ST_IDLE) && cmd_valid) begin
                r_addr     <= cmd_addr;
                r_len      <= cmd_len;
                r_size     <= cmd_size;
                r_beat_cnt <= '0;
                r_acc_resp <= '0;
            end else if (w_hs && ((r_state == ST_W) || (r_state == ST_R))) begin
                // The final beat leaves the count at len so it can never wrap.
                if (!w_beat_last) begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                end
                if (r_state == ST_R) begin
                    r_acc_resp <= w_r_resp;
                end
            end

            if ((r_state == ST_IDLE) || w_hs || w_timeout) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + c_WD_ONE;
            end
        end
    end

endmodule
`default_nettype wire
